// File: rtl/br_fifo_pkg.sv
// Shared CPU constants for the branch-register FIFO: control word layout, default widths,
// and the decode of push/pop/flush requests into a single operation.
package br_fifo_pkg;

  localparam int CTRL_W         = 25;
  localparam int DATA_WIDTH     = 16;
  localparam int CTRL_LOAD_BIT  = 12;
  localparam int CTRL_POP_BIT   = 13;
  localparam int CTRL_FLUSH_BIT = 14;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_PUSH_POP,
    OP_FLUSH
  } fifo_op_e;

  // Flush outranks push and pop requested on the same edge.
  function automatic fifo_op_e decode_op(input logic flush, input logic push, input logic pop);
    fifo_op_e op;
    if (flush)             op = OP_FLUSH;
    else if (push && pop)  op = OP_PUSH_POP;
    else if (push)         op = OP_PUSH;
    else if (pop)          op = OP_POP;
    else                   op = OP_IDLE;
    return op;
  endfunction

endpackage

// File: rtl/br_fifo_ptr.sv
// Pointer, occupancy and sticky-flag bookkeeping for br_fifo; reports which requests
// are accepted this cycle so the parent can update storage and last_val.
module br_fifo_ptr
  import br_fifo_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  fifo_op_e         op_i,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             ovf_o,
  output logic             unf_o,
  output logic             push_ok_o,
  output logic             pop_ok_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             empty, full;
  logic             push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // A full FIFO still accepts push+pop: the pop frees the slot the push fills.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    unique case (op_i)
      OP_PUSH: begin
        if (full) ovf_d   = 1'b1;
        else      push_ok = 1'b1;
      end
      OP_POP: begin
        if (empty) unf_d  = 1'b1;
        else       pop_ok = 1'b1;
      end
      OP_PUSH_POP: begin
        push_ok = 1'b1;
        pop_ok  = !empty;
      end
      OP_FLUSH: begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
    if (op_i == OP_FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign wr_ptr_o  = wr_ptr_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign count_o   = count_q;
  assign empty_o   = empty;
  assign full_o    = full;
  assign ovf_o     = ovf_q;
  assign unf_o     = unf_q;
  assign push_ok_o = push_ok && !rst;
  assign pop_ok_o  = pop_ok && !rst;

endmodule

// File: rtl/br_fifo.sv
// Branch-register FIFO driven by microinstruction control bits; holds the data array,
// the last-popped register and the head/last_val output mux.
module br_fifo
  import br_fifo_pkg::*;
#(
  parameter int WIDTH     = DATA_WIDTH,
  parameter int DEPTH     = 4,
  parameter int LOAD_BIT  = CTRL_LOAD_BIT,
  parameter int POP_BIT   = CTRL_POP_BIT,
  parameter int FLUSH_BIT = CTRL_FLUSH_BIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CTRL_W-1:0]        control,
  input  logic [WIDTH-1:0]         MBR_in,
  output logic [WIDTH-1:0]         BRout,
  output logic [$clog2(DEPTH):0]   br_count,
  output logic                     br_empty,
  output logic                     br_full,
  output logic                     br_ovf,
  output logic                     br_unf
);

  localparam int PTR_W = $clog2(DEPTH);

  fifo_op_e         op;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;
  logic             ctrl_unused;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] last_val_q;

  assign op          = decode_op(control[FLUSH_BIT], control[LOAD_BIT], control[POP_BIT]);
  assign ctrl_unused = ^control;

  br_fifo_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .op_i      (op),
    .wr_ptr_o  (wr_ptr),
    .rd_ptr_o  (rd_ptr),
    .count_o   (br_count),
    .empty_o   (br_empty),
    .full_o    (br_full),
    .ovf_o     (br_ovf),
    .unf_o     (br_unf),
    .push_ok_o (push_ok),
    .pop_ok_o  (pop_ok)
  );

  // NOTE: the data array has no reset; occupancy gates what BRout can show, so stale entries stay hidden.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr] <= MBR_in;
  end

  // On a full push+pop the write lands on the popped slot; last_val takes the pre-edge entry.
  always_ff @(posedge clk) begin
    if (rst)         last_val_q <= '0;
    else if (pop_ok) last_val_q <= mem_q[rd_ptr];
  end

  assign BRout = br_empty ? last_val_q : mem_q[rd_ptr];

endmodule

// File: tb/tb_br_fifo.sv
// Self-checking bench for br_fifo: a queue-based reference model feeds a scoreboard that a
// separate monitor drains one cycle later, plus directed checks of the key scenarios.
module tb_br_fifo;
  import br_fifo_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [CTRL_W-1:0] control;
  logic [WIDTH-1:0]  MBR_in;
  logic [WIDTH-1:0]  BRout;
  logic [CW-1:0]     br_count;
  logic              br_empty, br_full, br_ovf, br_unf;

  br_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .control  (control),
    .MBR_in   (MBR_in),
    .BRout    (BRout),
    .br_count (br_count),
    .br_empty (br_empty),
    .br_full  (br_full),
    .br_ovf   (br_ovf),
    .br_unf   (br_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] brout;
    int               count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] m_last;
  logic             m_ovf, m_unf;
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference behaviour: a plain queue plus last-popped value and sticky flags.
  task automatic model(input logic r, input logic pu, input logic po, input logic fl,
                       input logic [WIDTH-1:0] d);
    bit was_empty, was_full;
    if (r) begin
      model_q.delete();
      m_last = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else if (fl) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      was_empty = (model_q.size() == 0);
      was_full  = (model_q.size() == DEPTH);
      if (po && !was_empty) m_last = model_q.pop_front();
      if (pu) begin
        if (was_full && !po) m_ovf = 1'b1;
        else                 model_q.push_back(d);
      end else if (po && was_empty) begin
        m_unf = 1'b1;
      end
    end
  endtask

  // Drives one cycle of stimulus (applied on the next edge) and queues the expected result.
  task automatic step(input logic r, input logic pu, input logic po, input logic fl,
                      input logic [WIDTH-1:0] d);
    logic [CTRL_W-1:0] c;
    exp_t              e;
    @(posedge clk);
    #2;
    c                 = CTRL_W'($urandom);
    c[CTRL_LOAD_BIT]  = pu;
    c[CTRL_POP_BIT]   = po;
    c[CTRL_FLUSH_BIT] = fl;
    rst     = r;
    control = c;
    MBR_in  = d;
    model(r, pu, po, fl, d);
    e.brout = (model_q.size() != 0) ? model_q[0] : m_last;
    e.count = model_q.size();
    e.empty = (model_q.size() == 0);
    e.full  = (model_q.size() == DEPTH);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, WIDTH'($urandom));
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    step(1'b0, 1'b1, 1'b0, 1'b0, d);
  endtask

  task automatic pop();
    step(1'b0, 1'b0, 1'b1, 1'b0, WIDTH'($urandom));
  endtask

  task automatic flush();
    step(1'b0, 1'b0, 1'b0, 1'b1, WIDTH'($urandom));
  endtask

  // Monitor: one edge after each queued stimulus, compare the DUT outputs to the model.
  initial begin
    exp_t me;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        me = exp_q.pop_front();
        check("sb_brout", 32'(BRout), 32'(me.brout));
        check("sb_count", 32'(br_count), 32'(me.count));
        check("sb_empty", 32'(br_empty), 32'(me.empty));
        check("sb_full",  32'(br_full), 32'(me.full));
        check("sb_ovf",   32'(br_ovf), 32'(me.ovf));
        check("sb_unf",   32'(br_unf), 32'(me.unf));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // After step(X) returns, the DUT state reflects the step issued before X.
  initial begin
    rst     = 1'b1;
    control = '0;
    MBR_in  = '0;

    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle();
    check("rst_brout", 32'(BRout), 32'h0);
    check("rst_count", 32'(br_count), 32'h0);
    check("rst_empty", 32'(br_empty), 32'h1);
    check("rst_full",  32'(br_full), 32'h0);
    check("rst_ovf",   32'(br_ovf), 32'h0);
    check("rst_unf",   32'(br_unf), 32'h0);

    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    idle();
    check("order_head0", 32'(BRout), 32'h1111);
    pop();
    idle();
    check("order_head1", 32'(BRout), 32'h2222);
    pop();
    idle();
    check("order_head2", 32'(BRout), 32'h3333);
    pop();
    idle();
    check("order_last", 32'(BRout), 32'h3333);
    check("order_empty", 32'(br_empty), 32'h1);

    for (int i = 1; i <= 5; i++) push(WIDTH'(i * 16'h0101));
    idle();
    check("ovf_full",  32'(br_full), 32'h1);
    check("ovf_flag",  32'(br_ovf), 32'h1);
    check("ovf_count", 32'(br_count), 32'h4);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'hAAAA);
    idle();
    check("fullpp_count", 32'(br_count), 32'h4);
    check("fullpp_ovf",   32'(br_ovf), 32'h1);
    check("fullpp_head",  32'(BRout), 32'h0202);
    for (int i = 0; i < 4; i++) pop();
    idle();
    check("fullpp_last",  32'(BRout), 32'hAAAA);
    check("fullpp_empty", 32'(br_empty), 32'h1);

    flush();
    pop();
    idle();
    check("unf_flag",  32'(br_unf), 32'h1);
    check("unf_brout", 32'(BRout), 32'hAAAA);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h00FF);
    idle();
    check("emptypp_count", 32'(br_count), 32'h1);
    check("emptypp_brout", 32'(BRout), 32'h00FF);

    flush();
    push(16'h0A0A);
    push(16'h0B0B);
    push(16'h0C0C);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF);
    idle();
    check("flush_count", 32'(br_count), 32'h0);
    check("flush_ovf",   32'(br_ovf), 32'h0);
    check("flush_unf",   32'(br_unf), 32'h0);
    check("flush_brout", 32'(BRout), 32'hAAAA);

    for (int i = 0; i < 10; i++) begin
      push(WIDTH'(16'h0100 + i));
      idle();
      check("wrap_head", 32'(BRout), 32'(16'h0100 + i));
      pop();
    end
    idle();
    check("wrap_last",  32'(BRout), 32'h0109);
    check("wrap_empty", 32'(br_empty), 32'h1);

    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h5A5A);
    for (int i = 0; i < 600; i++) begin
      logic r, fl, pu, po;
      r  = ($urandom_range(99) == 0);
      fl = ($urandom_range(99) < 4);
      pu = ($urandom_range(99) < ((i < 300) ? 65 : 35));
      po = ($urandom_range(99) < ((i < 300) ? 40 : 60));
      step(r, pu, po, fl, WIDTH'($urandom));
    end
    idle();
    idle();
    @(posedge clk);
    #3;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/br_fifo.md
BR_FIFO -- requirements
Module: br_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data width of each buffer entry.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning number of entries; a power of two, at least 2.
REQ-003 The block SHALL have parameter LOAD_BIT, default 12, meaning the control bit that requests a push.
REQ-004 The block SHALL have parameter POP_BIT, default 13, meaning the control bit that requests a pop.
REQ-005 The block SHALL have parameter FLUSH_BIT, default 14, meaning the control bit that requests a flush.
REQ-006 The block SHALL have port clk, input, width 1, meaning the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst, input, width 1, meaning a synchronous, active-high reset.
REQ-008 The block SHALL have port control, input, width 25, meaning the microinstruction control word.
REQ-009 The block SHALL have port MBR_in, input, width WIDTH, meaning the data to push.
REQ-010 The block SHALL have port BRout, output, width WIDTH, meaning the head entry or the last popped value.
REQ-011 The block SHALL have port br_count, output, width $clog2(DEPTH)+1, meaning the number of occupied entries.
REQ-012 The block SHALL have port br_empty, output, width 1, meaning high when br_count==0.
REQ-013 The block SHALL have port br_full, output, width 1, meaning high when br_count==DEPTH.
REQ-014 The block SHALL have port br_ovf, output, width 1, meaning a sticky overflow flag.
REQ-015 The block SHALL have port br_unf, output, width 1, meaning a sticky underflow flag.

Function
REQ-016 The block SHALL decode push = control[LOAD_BIT], pop = control[POP_BIT] and flush = control[FLUSH_BIT], all sampled on the rising edge of clk.
REQ-017 A push accepted on edge N SHALL write MBR_in at wr_ptr and SHALL make the data visible to the head no earlier than after edge N.
REQ-018 When not empty, BRout SHALL equal the entry at rd_ptr, combinationally from storage.
REQ-019 When empty, BRout SHALL equal the last_val register.
REQ-020 On every accepted pop, the block SHALL load last_val with the popped entry.
REQ-021 Pointers SHALL wrap modulo DEPTH.
REQ-022 br_count SHALL be incremented on a push-only, decremented on a pop-only, and left unchanged when both a push and a pop are accepted.
REQ-023 When empty and push with pop both asserted, the block SHALL accept the push and ignore the pop, SHALL NOT set br_unf, and SHALL leave br_count at 1.
REQ-024 When full and push with pop both asserted, the block SHALL accept both, SHALL leave br_count at DEPTH, and SHALL NOT set br_ovf.
REQ-025 When full and push-only, the block SHALL drop the data, leave the storage unchanged, and set br_ovf.
REQ-026 When empty and pop-only, the block SHALL leave state unchanged except that it SHALL set br_unf.
REQ-027 A flush SHALL take priority over a push or pop on the same edge.
REQ-028 A flush SHALL zero the pointers and br_count, clear br_ovf and br_unf, and SHALL NOT change last_val.
REQ-029 Storage contents SHALL be don't-care after a flush and SHALL never be observable on BRout.
REQ-030 br_empty and br_full SHALL be combinational decodes of br_count only.

Reset
REQ-031 On rst high at a clk rising edge, the block SHALL set wr_ptr, rd_ptr, br_count, last_val, br_ovf and br_unf to 0; BRout SHALL then read 0, br_empty 1 and br_full 0.
REQ-032 rst SHALL override flush, push and pop on the same edge.
REQ-033 Asserting rst mid-operation SHALL discard all occupied entries with no partial update.
REQ-034 The storage array SHALL NOT require reset.

Structure
REQ-035 The shared CPU package SHALL hold the control-bit index constants (LOAD_BIT, POP_BIT, FLUSH_BIT) and the WIDTH default; the control word width of 25 SHALL remain a package constant.
REQ-036 The design SHALL use one sub-module, br_fifo_ptr, holding the pointer/count logic with wrap and the full/empty decode; the storage and BRout mux SHALL stay in br_fifo.

Verification
REQ-037 The bench SHALL check reset: rst for 1 cycle -> BRout=0, br_count=0, br_empty=1, br_ovf=0, br_unf=0.
REQ-038 The bench SHALL check in-order push/pop: push 0x1111, 0x2222, 0x3333, then pop x3 -> BRout reads 0x1111, 0x2222, 0x3333 in turn, then last_val 0x3333 with br_empty=1.
REQ-039 The bench SHALL check overflow and full simultaneous push/pop: push 5 values with DEPTH=4 -> br_full=1, br_ovf=1, 5th value absent; then push 0xAAAA with pop -> br_count stays 4, br_ovf stays 1, 0xAAAA later read last.
REQ-040 The bench SHALL check empty behaviour: pop while empty -> br_unf=1, BRout unchanged; push 0x00FF with pop while empty -> br_count=1, BRout=0x00FF.
REQ-041 The bench SHALL check flush: after 3 pushes, flush with push asserted -> br_count=0, flags clear, BRout=last_val.
REQ-042 The bench SHALL check wrap: 10 alternating push/pop of incrementing data -> pointers wrap with no data corruption.
